uart_rx_buffered: RTL and testbench

Serial receive front end for the debug/loader UART link. It replaces the bare receiver feeding the command controller. It synchronises the RX pin, samples 8N1 frames at mid-bit, checks the stop bit, and queues good bytes in a small FIFO. The consumer drains the FIFO with a valid/pop handshake, so bytes are not lost while it is busy or transmitting.

---
 rtl/uart_rx_buffered_pkg.sv | 15 +
 rtl/uart_rx_buffered_byte_fifo.sv | 59 +++++
 rtl/uart_rx_buffered.sv | 133 +++++++++++++
 tb/tb_uart_rx_buffered.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_CLKS_PER_BIT_25MHZ = 50;
  localparam int UART_CLKS_PER_BIT_50MHZ = 100;

endpackage

// File: rtl/uart_rx_buffered_byte_fifo.sv
// Small byte FIFO with extra-bit pointers and a sticky overflow flag.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       overflow_clear,
  output logic       full,
  output logic       empty,
  output logic [7:0] head,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;
  logic        ovf_set;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop on an empty FIFO is ignored; a full FIFO accepts a push only
  // when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !do_pop;

  assign head = empty ? 8'h00 : mem[rptr[AW-1:0]];

  // Pointer and sticky overflow state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (ovf_set)             overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with input synchroniser, mid-bit sampling, stop-bit
// check and a byte FIFO drained through a valid/pop handshake.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_25MHZ,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx_pin,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       rx_pop,
  output logic       framing_error,
  output logic       overflow,
  input  logic       overflow_clear
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic            rx_sync_p0;
  logic            rx_sync_p1;
  logic            rxs;
  rx_state_t       state;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_q;
  logic            byte_push;
  logic            fifo_full;
  logic            fifo_empty;

  // Two-flop synchroniser; idles high so reset looks like a quiet line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx_pin;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rxs = rx_sync_p1;

  // Frame decoder: half-bit into the start bit, then whole bits to land
  // mid-bit on each data bit and on the stop bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data bits land LSB first at the mid-bit sample point.
  always_ff @(posedge clock) begin
    if (state == DATA && clk_cnt == CNT_LAST) shift_q[bit_idx] <= rxs;
  end

  // A good stop bit hands the byte to the FIFO in the sample cycle itself,
  // so the FSM is back in IDLE mid stop bit and catches back-to-back frames.
  assign byte_push = (state == STOP) && (clk_cnt == CNT_LAST) && rxs;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock          (clock),
    .reset_n        (reset_n),
    .push           (byte_push),
    .push_data      (shift_q),
    .pop            (rx_pop),
    .overflow_clear (overflow_clear),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .head           (rx_byte),
    .overflow       (overflow)
  );

  assign rx_valid = !fifo_empty;

  // The pointer compare can never report full and empty together.
  assert property (@(posedge clock) disable iff (!reset_n) !(fifo_full && fifo_empty));

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor
// compares every byte the consumer pops.
module tb_uart_rx_buffered;

  localparam int C = 50;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       rx_pop = 1'b0;
  logic       overflow_clear = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       framing_error;
  logic       overflow;

  int         total = 0;
  int         bad = 0;
  int         fe_count = 0;
  int         fe_exp = 0;
  bit         ovf_exp = 1'b0;
  logic [7:0] exp_q [$];

  uart_rx_buffered #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .uart_rx_pin    (uart_rx_pin),
    .rx_valid       (rx_valid),
    .rx_byte        (rx_byte),
    .rx_pop         (rx_pop),
    .framing_error  (framing_error),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: count framing pulses, score every accepted pop.
  always @(negedge clock) begin
    if (framing_error) fe_count++;
    if (reset_n && rx_pop && rx_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %02h required no byte", rx_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("pop_byte", rx_byte, e);
      end
    end
  end

  // One 10-bit frame; all tasks start and end just after a rising edge.
  // Stop sample lands 477 cycles after the start edge is driven, so push
  // and framing_error become visible on cycle 478.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low,
                            input bit chk, input bit pop_at_stop);
    for (int k = 0; k < 10 * C; k++) begin
      int slot;
      slot = k / C;
      if (slot == 0)      uart_rx_pin = 1'b0;
      else if (slot <= 8) uart_rx_pin = b[slot-1];
      else                uart_rx_pin = stop_ok;
      rx_pop = pop_at_stop && (k == 477);
      if (chk && (k >= 477) && (k <= 479)) begin
        @(negedge clock);
        if (stop_ok) begin
          if (k == 477) check("valid_before_push", rx_valid, 0);
          if (k == 478) begin
            check("valid_after_push", rx_valid, 1);
            check("byte_after_push", rx_byte, b);
          end
          check("no_ferr_good_frame", framing_error, 0);
        end else begin
          check("ferr_pulse_timing", framing_error, (k == 478));
        end
      end
      @(posedge clock); #1;
    end
    rx_pop = 1'b0;
    repeat (extra_low * C) begin
      uart_rx_pin = 1'b0;
      @(posedge clock); #1;
    end
    uart_rx_pin = 1'b1;
    // Reference: a good byte is kept if there is room (or the head left
    // in the same cycle), otherwise it is lost and overflow latches.
    if (stop_ok) begin
      if (exp_q.size() < D || pop_at_stop) exp_q.push_back(b);
      else ovf_exp = 1'b1;
    end else begin
      fe_exp++;
    end
  endtask

  task automatic idle(input int n);
    uart_rx_pin = 1'b1;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rx_pop = 1'b1;
      @(posedge clock); #1;
      rx_pop = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D && rx_valid; i++) begin
      rx_pop = 1'b1;
      @(posedge clock); #1;
      rx_pop = 1'b0;
    end
    check("drained_empty", rx_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pb;
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_ferr", framing_error, 0);
    check("reset_overflow", overflow, 0);
    reset_n = 1'b1;
    idle(10);

    // Basic frame with latency checks
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    check("ferr_count_a5", fe_count, fe_exp);
    drain();

    // Short low glitch: no frame, no framing error
    uart_rx_pin = 1'b0;
    repeat (15) begin @(posedge clock); #1; end
    idle(100);
    check("glitch_no_valid", rx_valid, 0);
    check("glitch_no_ferr", fe_count, fe_exp);

    // Bad stop bit, long break, then a good frame
    send_frame(8'h3C, 1'b0, 20, 1'b1, 1'b0);
    check("break_fifo_empty", rx_valid, 0);
    idle(20);
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
    check("ferr_count_break", fe_count, fe_exp);
    drain();

    // Five back-to-back frames into a depth-4 FIFO
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 0, 1'b0, 1'b0);
    idle(5);
    check("overflow_set", overflow, ovf_exp);
    check("overflow_valid", rx_valid, 1);
    idle(20);
    check("overflow_sticky", overflow, 1);
    overflow_clear = 1'b1;
    @(posedge clock); #1;
    overflow_clear = 1'b0;
    ovf_exp = 1'b0;
    check("overflow_cleared", overflow, ovf_exp);
    pop_n(4);
    check("overflow_drained", rx_valid, 0);

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < D; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 1'b0);
    idle(3);
    send_frame(8'h77, 1'b1, 0, 1'b0, 1'b1);
    idle(3);
    check("full_pop_no_overflow", overflow, 0);
    drain();

    // Reset during bit 4 with two bytes queued
    send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 1'b0);
    check("queued_valid", rx_valid, 1);
    pb = 8'h96;
    for (int k = 0; k < 5 * C + C / 2; k++) begin
      uart_rx_pin = (k < C) ? 1'b0 : pb[k / C - 1];
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    check("reset_mid_valid", rx_valid, 0);
    check("reset_mid_byte", rx_byte, 0);
    exp_q.delete();
    uart_rx_pin = 1'b1;
    @(posedge clock); #1;
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b0);
    check("after_reset_valid", rx_valid, 1);
    drain();

    // Randomised frames, gaps and stop bits
    for (int n = 0; n < 10; n++) begin
      bit ok;
      ok = ($urandom_range(0, 5) != 0);
      send_frame(8'($urandom_range(0, 255)), ok, 0, 1'b0, 1'b0);
      idle($urandom_range(3, 40));
      check("rand_no_overflow", overflow, 0);
      drain();
    end

    idle(10);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_ferr_count", fe_count, fe_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
